// File: rtl/addroundkey_ks_if.sv
// Handshake and data bus between a cipher controller (master) and the
// AddRoundKey/key-schedule stage (slave).
interface addroundkey_ks_if;
  logic         key_load;
  logic [127:0] key_in;
  logic         ena;
  logic [127:0] state_in;
  logic [127:0] state_out;
  logic         done;
  logic         last;
  logic [3:0]   round_out;
  logic         busy;

  modport master (
    output key_load, key_in, ena, state_in,
    input  state_out, done, last, round_out, busy
  );

  modport slave (
    input  key_load, key_in, ena, state_in,
    output state_out, done, last, round_out, busy
  );
endinterface

// File: rtl/addroundkey_ks.sv
// AES-128 AddRoundKey with an on-the-fly key schedule: each accepted beat XORs
// the current round key into the state, then advances the key by one round.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y = SBOX[a];
endmodule

module aes_xtime (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Multiply by x in GF(2^8), reducing by the AES polynomial.
  assign y = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
endmodule

module addroundkey_ks #(
  parameter int NUM_ROUNDS = 10
) (
  input logic              clk,
  input logic              rst,
  addroundkey_ks_if.slave  bus
);
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {IDLE, ADD, UPDATE} state_t;

  state_t       state, state_next;
  logic [127:0] cipher_key, round_key, data_reg, state_out_q;
  logic [7:0]   rcon, rcon_next;
  logic [3:0]   round;
  logic         done_q, last_q;
  logic         key_we, data_we, add_step, upd_step;

  // Next round key: RotWord + SubWord of w3, rcon into row 0, then the word chain.
  logic [31:0]  w3, sub_w, t;
  logic [31:0]  nw0, nw1, nw2, nw3;
  logic [127:0] next_key;

  assign w3 = round_key[127:96];

  for (genvar r = 0; r < 4; r++) begin : g_sbox
    aes_sbox u_sbox (.a(w3[8*((r+1)%4) +: 8]), .y(sub_w[8*r +: 8]));
  end

  aes_xtime u_xtime (.a(rcon), .y(rcon_next));

  assign t        = {sub_w[31:8], sub_w[7:0] ^ rcon};
  assign nw0      = round_key[31:0]   ^ t;
  assign nw1      = round_key[63:32]  ^ nw0;
  assign nw2      = round_key[95:64]  ^ nw1;
  assign nw3      = round_key[127:96] ^ nw2;
  assign next_key = {nw3, nw2, nw1, nw0};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!bus.key_load && bus.ena) state_next = ADD;
      ADD:     state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every signal gets a default at the top of the comb block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    key_we   = 1'b0;
    data_we  = 1'b0;
    add_step = 1'b0;
    upd_step = 1'b0;
    unique case (state)
      IDLE:    begin
                 key_we  = bus.key_load;
                 data_we = !bus.key_load && bus.ena;
               end
      ADD:     add_step = 1'b1;
      UPDATE:  upd_step = 1'b1;
      default: ;
    endcase
  end

  // Key registers are reset too: after an abort the stage must not leak the
  // previous cipher key into the next (unkeyed) operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cipher_key  <= '0;
      round_key   <= '0;
      data_reg    <= '0;
      state_out_q <= '0;
      rcon        <= 8'h01;
      round       <= '0;
      done_q      <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      done_q <= add_step;
      last_q <= add_step && (round == LAST_ROUND);
      if (key_we) begin
        cipher_key <= bus.key_in;
        round_key  <= bus.key_in;
        round      <= '0;
        rcon       <= 8'h01;
      end
      if (data_we)  data_reg    <= bus.state_in;
      if (add_step) state_out_q <= data_reg ^ round_key;
      if (upd_step) begin
        if (round < LAST_ROUND) begin
          round_key <= next_key;
          rcon      <= rcon_next;
          round     <= round + 4'd1;
        end else begin
          round_key <= cipher_key;
          rcon      <= 8'h01;
          round     <= '0;
        end
      end
    end
  end

  assign bus.state_out = state_out_q;
  assign bus.done      = done_q;
  assign bus.last      = last_q;
  assign bus.round_out = round;
  assign bus.busy      = (state != IDLE);
endmodule
